// File: rtl/register_file_sequencer_pkg.sv
// register_file_sequencer_pkg: shared opcode/state types and widths for the sequencer
package register_file_sequencer_pkg;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 2;
  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_MOV = 3'b001,
    OP_LDI = 3'b010,
    OP_ADD = 3'b011,
    OP_SUB = 3'b100,
    OP_AND = 3'b101,
    OP_OR  = 3'b110,
    OP_XOR = 3'b111
  } op_t;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;
endpackage

// File: rtl/register_file_4.sv
// register_file_4: 4x4-bit register file, two async read ports, one sync write port
module register_file_4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] read_addr_0,
  input  logic [1:0] read_addr_1,
  output logic [3:0] read_data_0,
  output logic [3:0] read_data_1,
  input  logic [1:0] write_addr,
  input  logic [3:0] write_data,
  input  logic       write_enable
);
  logic [3:0] regs [4];
  // storage: cleared on rst, otherwise written on the strobe
  always_ff @(posedge clk)
    if (rst) regs <= '{default: '0};
    else if (write_enable) regs[write_addr] <= write_data;
  assign read_data_0 = regs[read_addr_0];
  assign read_data_1 = regs[read_addr_1];
endmodule

// File: rtl/register_file_sequencer_alu_4.sv
// alu_4: combinational 4-bit ALU with carry/borrow for ADD and SUB
module alu_4
  import register_file_sequencer_pkg::*;
(
  input  op_t               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              carry_valid
);
  logic [DATA_W:0] sum, diff;
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  // opcode decode; the borrow of SUB falls out as the top bit of the wide difference
  always_comb begin
    result = '0;
    carry = 1'b0;
    carry_valid = op == OP_ADD || op == OP_SUB;
    case (op)
      OP_MOV: result = a;
      OP_LDI: result = imm;
      OP_ADD: {carry, result} = sum;
      OP_SUB: {carry, result} = diff;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/register_file_sequencer.sv
// register_file_sequencer: four-cycle read/exec/write micro-sequencer driving register_file_4
module register_file_sequencer #(
  parameter  int N_REGS = 4,
  parameter  int DATA_W = 4,
  localparam int AW = $clog2(N_REGS)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_op,
  input  logic [AW-1:0]     i_rd,
  input  logic [AW-1:0]     i_ra,
  input  logic [AW-1:0]     i_rb,
  input  logic [DATA_W-1:0] i_imm,
  output logic [AW-1:0]     o_reg_read_0,
  output logic [AW-1:0]     o_reg_read_1,
  input  logic [DATA_W-1:0] i_port_read_0,
  input  logic [DATA_W-1:0] i_port_read_1,
  output logic [AW-1:0]     o_reg_write,
  output logic [DATA_W-1:0] o_port_write,
  output logic              o_write_enable,
  output logic              o_done,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry
);
  import register_file_sequencer_pkg::*;
  state_t state, state_nx;
  op_t op;
  logic [AW-1:0] rd;
  logic [DATA_W-1:0] imm, alu_result;
  logic alu_carry, alu_carry_valid;
  logic accept;
  assign accept = state == IDLE && i_valid;
  // state register
  always_ff @(posedge i_clk) state <= i_reset ? IDLE : state_nx;
  // next state walks IDLE->READ->EXEC->WRITE->IDLE, holding in IDLE until valid; strobes decode from state
  always_comb begin
    state_nx = state;
    o_ready = state == IDLE;
    o_done = state == WRITE;
    o_write_enable = state == WRITE && op != OP_NOP;
    if (state != IDLE || i_valid) state_nx = state_t'(state + 2'd1);
  end
  // latch the instruction on accept, register the ALU result at the end of EXEC
  always_ff @(posedge i_clk)
    if (i_reset) begin
      op <= OP_NOP;
      rd <= '0;
      imm <= '0;
      o_reg_read_0 <= '0;
      o_reg_read_1 <= '0;
      o_result <= '0;
      o_carry <= 1'b0;
    end else if (accept) begin
      op <= op_t'(i_op);
      rd <= i_rd;
      imm <= i_imm;
      o_reg_read_0 <= i_ra;
      o_reg_read_1 <= i_rb;
    end else if (state == EXEC && op != OP_NOP) begin
      o_result <= alu_result;
      if (alu_carry_valid) o_carry <= alu_carry;
    end
  assign o_reg_write = rd;
  assign o_port_write = o_result;
  alu_4 u_alu (
    .op(op),
    .a(i_port_read_0),
    .b(i_port_read_1),
    .imm(imm),
    .result(alu_result),
    .carry(alu_carry),
    .carry_valid(alu_carry_valid)
  );
endmodule
